// File: rtl/restador_pkg.sv
// restador_pkg: shared state encoding and parameter legality check for the serial subtractor
package restador_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
  function automatic bit params_ok(input int width, input int digit);
    return width >= 2 && digit >= 1 && (width % digit) == 0;
  endfunction
endpackage

// File: rtl/restador_digito.sv
// restador_digito: combinational DIGIT-bit ripple subtractor slice with MSB borrow-in for overflow
module restador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_d,
  output logic             o_cout,
  output logic             o_cmsb
);
  logic [DIGIT:0] w_c;
  // ripple the borrow through the slice, one full subtractor per bit
  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    o_d    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      o_d[i]   = i_x[i] ^ i_y[i] ^ w_c[i];
      w_c[i+1] = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & w_c[i]);
    end
  end
  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];
endmodule

// File: rtl/restador_serie.sv
// restador_serie: digit-serial subtractor computing a - b - bin, LSB slice first
module restador_serie
  import restador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!params_ok(WIDTH, DIGIT)) begin : g_bad_params
    $fatal(1, "restador_serie: WIDTH=%0d must be >= 2 and a multiple of DIGIT=%0d", WIDTH, DIGIT);
  end

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_diff, w_diff_nx;
  logic             r_borrow, r_bout, r_ovf, r_zero;
  logic [DIGIT-1:0] w_d;
  logic             w_cout, w_cmsb, w_last;

  // operands shift right each digit, so the active slice is always the low DIGIT bits
  restador_digito #(.DIGIT(DIGIT)) u_digito (
    .i_x   (r_a[DIGIT-1:0]),
    .i_y   (r_b[DIGIT-1:0]),
    .i_cin (r_borrow),
    .o_d   (w_d),
    .o_cout(w_cout),
    .o_cmsb(w_cmsb)
  );

  assign w_last    = r_cnt == LAST;
  assign w_diff_nx = WIDTH'({w_d, r_diff} >> DIGIT);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // next-state and status decode
  always_comb begin
    w_state_nx = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: w_state_nx = start ? RUN : IDLE;
      RUN: begin
        busy       = 1'b1;
        w_state_nx = w_last ? DONE : RUN;
      end
      DONE: begin
        done       = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // datapath: latch on accepted start, one slice per RUN edge, flags captured on the last slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_cnt    <= '0;
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_diff   <= '0;
    end else if (r_state == RUN) begin
      r_cnt    <= r_cnt + 1'b1;
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_borrow <= w_cout;
      r_diff   <= w_diff_nx;
      if (w_last) begin
        r_bout <= w_cout;
        r_ovf  <= w_cmsb ^ w_cout;
        r_zero <= w_diff_nx == '0;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
endmodule

// File: tb/tb_restador_serie.sv
// tb_restador_serie: randomized self-checking bench against an arithmetic reference model
module tb_restador_serie;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       bin_in = 1'b0;
  logic       st [4];
  logic [7:0] d0, d1;
  logic [1:0] d2;
  logic [3:0] d3;
  logic       bo [4], ov [4], zr [4], bs [4], dn [4];
  logic [0:0] tx, ty, td;
  logic       tc, tco, tcm;
  int         n_tests = 0, n_fail = 0;
  int         wd [4] = '{8, 8, 2, 4};
  int         nn [4] = '{8, 2, 2, 1};

  always #5 clk = ~clk;

  restador_serie #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .a(a_in), .b(b_in),
    .bin(bin_in), .diff(d0), .bout(bo[0]), .ovf(ov[0]), .zero(zr[0]), .busy(bs[0]), .done(dn[0]));
  restador_serie #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .a(a_in), .b(b_in),
    .bin(bin_in), .diff(d1), .bout(bo[1]), .ovf(ov[1]), .zero(zr[1]), .busy(bs[1]), .done(dn[1]));
  restador_serie #(.WIDTH(2), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .a(a_in[1:0]), .b(b_in[1:0]),
    .bin(bin_in), .diff(d2), .bout(bo[2]), .ovf(ov[2]), .zero(zr[2]), .busy(bs[2]), .done(dn[2]));
  restador_serie #(.WIDTH(4), .DIGIT(4)) u3 (.clk(clk), .rst_n(rst_n), .start(st[3]), .a(a_in[3:0]), .b(b_in[3:0]),
    .bin(bin_in), .diff(d3), .bout(bo[3]), .ovf(ov[3]), .zero(zr[3]), .busy(bs[3]), .done(dn[3]));
  restador_digito #(.DIGIT(1)) u_dig (.i_x(tx), .i_y(ty), .i_cin(tc), .o_d(td), .o_cout(tco), .o_cmsb(tcm));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dif(input int i);
    return i == 0 ? d0 : i == 1 ? d1 : i == 2 ? {6'b0, d2} : {4'b0, d3};
  endfunction

  // reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void ref_sub(input int w, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                                  output logic [7:0] d, output logic be, output logic oe);
    int m = 1 << w;
    int ai = int'(av) % m;
    int bi = int'(bv) % m;
    int r = ai - bi - int'(cv);
    int sa = ai >= m / 2 ? ai - m : ai;
    int sb = bi >= m / 2 ? bi - m : bi;
    int sr = sa - sb - int'(cv);
    d  = 8'((r + 2 * m) % m);
    be = r < 0;
    oe = sr < -(m / 2) || sr >= m / 2;
  endfunction

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv, input bit inject, input bit abort);
    logic [7:0] ed [4];
    logic       eb [4], eo [4];
    int         cnt [4], de [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      ref_sub(wd[i], av, bv, cv, ed[i], eb[i], eo[i]);
      cnt[i] = 0;
      de[i]  = 0;
    end
    @(negedge clk);
    a_in = av; b_in = bv; bin_in = cv;
    for (int i = 0; i < 4; i++) st[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) st[i] = 1'b0;
    r = $urandom; a_in = r[7:0]; b_in = r[15:8]; bin_in = r[16];
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (dn[i]) begin
        cnt[i]++;
        de[i] = k + 1;
        check($sformatf("busy_in_done%0d", i), 32'(bs[i]), 0);
        check($sformatf("diff_at_done%0d", i), 32'(dif(i)), 32'(ed[i]));
      end
      if (abort && k == 4) begin
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
          check($sformatf("rst_diff%0d", i), 32'(dif(i)), 0);
          check($sformatf("rst_flags%0d", i), {28'b0, bo[i], ov[i], zr[i], bs[i]}, 0);
          check($sformatf("rst_done%0d", i), 32'(dn[i]), 0);
        end
      end
      if (abort && k == 6) rst_n = 1'b1;
      st[0] = inject && k == 3;
      if (inject && k == 3) begin
        r = $urandom; a_in = r[7:0]; b_in = r[15:8]; bin_in = r[16];
      end
    end
    if (abort) check("abort_no_done", 32'(cnt[0]), 0);
    else for (int i = 0; i < 4; i++) begin
      check($sformatf("done_count%0d", i), 32'(cnt[i]), 1);
      check($sformatf("done_edge%0d", i), 32'(de[i]), 32'(nn[i] + 1));
      check($sformatf("diff%0d", i), 32'(dif(i)), 32'(ed[i]));
      check($sformatf("bout%0d", i), 32'(bo[i]), 32'(eb[i]));
      check($sformatf("ovf%0d", i), 32'(ov[i]), 32'(eo[i]));
      check($sformatf("zero%0d", i), 32'(zr[i]), 32'(ed[i] == 8'd0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int first, second;
    for (int i = 0; i < 4; i++) st[i] = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_diff%0d", i), 32'(dif(i)), 0);
      check($sformatf("reset_flags%0d", i), {27'b0, bo[i], ov[i], zr[i], bs[i], dn[i]}, 0);
    end
    #12 rst_n = 1'b1;
    run_op(8'h05, 8'h03, 1'b0, 0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0, 0);
    run_op(8'h80, 8'h01, 1'b0, 0, 0);
    run_op(8'h10, 8'h0F, 1'b1, 0, 0);
    run_op(8'h5A, 8'h33, 1'b0, 1, 0);
    run_op(8'hC3, 8'h3C, 1'b1, 0, 1);
    check("zero_after_reset", 32'(zr[0]), 0);
    run_op(8'h21, 8'h42, 1'b0, 0, 0);
    for (int c = 0; c < 32; c++) begin
      r = $urandom;
      run_op({r[7:2], 2'(c)}, {r[15:10], 2'(c >> 2)}, c[4], 0, 0);
    end
    for (int t = 0; t < 20; t++) begin
      r = $urandom;
      run_op(r[7:0], r[15:8], r[16], 0, 0);
    end
    @(negedge clk);
    a_in = 8'h37; b_in = 8'h59; bin_in = 1'b1; st[0] = 1'b1;
    first = -1; second = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dn[0]) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    st[0] = 1'b0;
    check("b2b_first", 32'(first), 9);
    check("b2b_gap", 32'(second - first), 10);
    check("b2b_diff", 32'(d0), 32'(8'hDD));
    repeat (12) @(negedge clk);
    for (int v = 0; v < 8; v++) begin
      tx = 1'(v >> 2); ty = 1'(v >> 1); tc = 1'(v);
      #1;
      check($sformatf("slice_d%0d", v), 32'(td), 32'((int'(tx) - int'(ty) - int'(tc) + 4) % 2));
      check($sformatf("slice_b%0d", v), 32'(tco), 32'(int'(tx) < int'(ty) + int'(tc)));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/restador_serie.md
RESTADOR_SERIE -- requirements
Module: restador_serie

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal values >= 2.
REQ-002 Parameter DIGIT, default 1: bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request: latch operands and begin a subtraction.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-010 bout  output  1  borrow-out; 1 when unsigned a < b + bin.
REQ-011 ovf  output  1  signed two's-complement overflow of a - b - bin.
REQ-012 zero  output  1  diff == 0.
REQ-013 busy  output  1  high in RUN state.
REQ-014 done  output  1  one-cycle pulse; results valid.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after N = WIDTH/DIGIT digit cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 At the edge sampling start=1 in IDLE: latch a, b, bin; clear digit counter; clear diff.
REQ-017 Each RUN edge SHALL subtract one DIGIT-bit slice, LSB slice first, and propagate the borrow into the next slice.
- Each bit uses full-subtractor equations: d = x^y^c; borrow = (~x&y) | (~(x^y)&c).
REQ-018 Counter SHALL be ceil(log2(N+1)) bits wide, increment once per RUN edge, and terminate on reaching N-1; no wrap-around beyond N.
REQ-019 done SHALL be high exactly during the DONE cycle, i.e. N+1 edges after the start-sampling edge; busy SHALL be low in that cycle.
REQ-020 diff, bout, ovf and zero SHALL be final when done=1 and held unchanged until the next accepted start.
REQ-021 ovf SHALL equal the borrow into the MSB XOR the borrow out of the MSB.
REQ-022 start while in RUN or DONE SHALL be ignored, with no effect on operands or progress; a, b and bin changing during RUN SHALL have no effect.
REQ-023 start held high SHALL begin a new operation on the first IDLE edge after DONE; back-to-back throughput is one result per N+2 cycles.
REQ-024 WIDTH=DIGIT (N=1) SHALL complete with done two edges after start.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, counter 0, and diff, bout, ovf, zero, busy, done all 0, regardless of clock.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.
REQ-027 zero SHALL read 0 out of reset (not derived from diff) until the first done.

Structure
REQ-028 Shared package restador_pkg SHALL hold the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH/DIGIT legality check.
REQ-029 One sub-module, restador_digito, SHALL implement a purely combinational DIGIT-bit ripple subtractor slice (x, y, cin -> d, cout, plus MSB carry-in for ovf); restador_serie instantiates it once.
REQ-030 Illegal parameters (WIDTH%DIGIT != 0 or WIDTH < 2) SHALL halt elaboration with a message.

Verification
REQ-031 WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> done at edge 9; diff=0x02, bout=0, ovf=0, zero=0.
REQ-032 WIDTH=8, DIGIT=1: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
REQ-033 WIDTH=8, DIGIT=4: a=0x10, b=0x0F, bin=1 -> done at edge 3; diff=0x00, zero=1, bout=0.
REQ-034 WIDTH=2, DIGIT=1: all 32 combinations of a, b, bin -> diff/bout match reference arithmetic; 1-bit slice matches the 8-row full-subtractor truth table.
REQ-035 start pulsed at RUN cycle 3 with different operands -> ignored; original result delivered; single done pulse.
REQ-036 rst_n low at RUN cycle 4 -> all outputs 0 immediately, no done; new start after release -> correct result at edge N+1.
